// File: rtl/execute_alu_shift_pipe_pkg.sv
// Shared opcode constants for the execute-cluster shifter, plus the helpers
// that split the binary shift steps across the pipeline stages.
package execute_alu_shift_pipe_pkg;

  localparam int ALU_SHIFT_OP_W = 3;

  localparam logic [ALU_SHIFT_OP_W-1:0] ALU_SHIFT_SLL = 3'd0;
  localparam logic [ALU_SHIFT_OP_W-1:0] ALU_SHIFT_SRL = 3'd1;
  localparam logic [ALU_SHIFT_OP_W-1:0] ALU_SHIFT_SRA = 3'd2;
  localparam logic [ALU_SHIFT_OP_W-1:0] ALU_SHIFT_ROL = 3'd3;
  localparam logic [ALU_SHIFT_OP_W-1:0] ALU_SHIFT_ROR = 3'd4;

  // Earlier stages absorb the remainder when saw does not divide evenly.
  function automatic int stage_nstep(input int saw, input int stages, input int idx);
    return (saw / stages) + ((idx < (saw % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first(input int saw, input int stages, input int idx);
    return (idx * (saw / stages)) + ((idx < (saw % stages)) ? idx : (saw % stages));
  endfunction

endpackage

// File: rtl/execute_alu_shift_stage.sv
// Combinational slice of the barrel shifter: applies steps 2^k for
// k = FIRST_STEP .. FIRST_STEP+NUM_STEPS-1 selected by the local amount bits.
module execute_alu_shift_stage
  import execute_alu_shift_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIRST_STEP = 0,
  parameter int NUM_STEPS  = 1
) (
  input  logic [WIDTH-1:0]          data_i,
  input  logic [NUM_STEPS-1:0]      sa_i,
  input  logic [ALU_SHIFT_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]          data_o
);

  logic [WIDTH-1:0] acc;

  // ROL never reaches here: it is rewritten as ROR upstream. Unused codes fall to SLL.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] x,
                                                  input logic [ALU_SHIFT_OP_W-1:0] op,
                                                  input int amt);
    logic signed [WIDTH-1:0] xs;
    logic [WIDTH-1:0]        r;
    xs = x;
    case (op)
      ALU_SHIFT_SRL: r = x >> amt;
      ALU_SHIFT_SRA: r = xs >>> amt;
      ALU_SHIFT_ROR: r = (x >> amt) | (x << (WIDTH - amt));
      default:       r = x << amt;
    endcase
    return r;
  endfunction

  always_comb begin
    acc = data_i;
    for (int j = 0; j < NUM_STEPS; j++) begin
      if (sa_i[j]) acc = shift_step(acc, op_i, 1 << (FIRST_STEP + j));
    end
    data_o = acc;
  end

endmodule

// File: rtl/execute_alu_shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready handshake, tag
// passthrough and flush; the shift steps are spread over STAGES registers.
module execute_alu_shift_pipe
  import execute_alu_shift_pipe_pkg::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  STAGES = 2,
  parameter int  TAG_W  = 6,
  localparam int SAW    = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          d0,
  input  logic [SAW-1:0]            sa0,
  input  logic [SAW-1:0]            sa1,
  input  logic                      sa_sel,
  input  logic [ALU_SHIFT_OP_W-1:0] sel,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          s0,
  output logic [TAG_W-1:0]          out_tag
);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] load, up_v, ld_en;

  logic [WIDTH-1:0]          data_q [STAGES];
  logic [TAG_W-1:0]          tag_q  [STAGES];
  logic [SAW-1:0]            sa_q   [STAGES];
  logic [ALU_SHIFT_OP_W-1:0] op_q   [STAGES];

  logic [WIDTH-1:0]          st_din  [STAGES];
  logic [WIDTH-1:0]          st_dout [STAGES];
  logic [TAG_W-1:0]          st_tag  [STAGES];
  logic [SAW-1:0]            st_sa   [STAGES];
  logic [ALU_SHIFT_OP_W-1:0] st_op   [STAGES];

  logic [SAW-1:0] sa_raw;
  logic           full;

  // ROL by n equals ROR by (WIDTH - n) mod WIDTH, which is -n in SAW bits.
  always_comb begin
    sa_raw    = sa_sel ? sa1 : sa0;
    st_din[0] = d0;
    st_tag[0] = in_tag;
    st_sa[0]  = sa_raw;
    st_op[0]  = sel;
    up_v[0]   = in_valid;
    if (sel == ALU_SHIFT_ROL) begin
      st_sa[0] = -sa_raw;
      st_op[0] = ALU_SHIFT_ROR;
    end
    for (int i = 1; i < STAGES; i++) begin
      st_din[i] = data_q[i-1];
      st_tag[i] = tag_q[i-1];
      st_sa[i]  = sa_q[i-1];
      st_op[i]  = op_q[i-1];
      up_v[i]   = v_q[i-1];
    end
  end

  // A stage can load unless it and every stage after it are full and the
  // consumer is stalling; this avoids a bit-to-bit ripple through load[].
  always_comb begin
    full = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full    = full & v_q[i];
      load[i] = ~full | out_ready;
    end
    for (int i = 0; i < STAGES; i++) begin
      ld_en[i] = load[i] & up_v[i];
      v_d[i]   = flush ? 1'b0 : (load[i] ? up_v[i] : v_q[i]);
    end
    in_ready = load[0] | flush;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int FIRST = stage_first(SAW, STAGES, g);
    localparam int NSTEP = stage_nstep(SAW, STAGES, g);

    execute_alu_shift_stage #(
      .WIDTH     (WIDTH),
      .FIRST_STEP(FIRST),
      .NUM_STEPS (NSTEP)
    ) u_stage (
      .data_i(st_din[g]),
      .sa_i  (st_sa[g][FIRST +: NSTEP]),
      .op_i  (st_op[g]),
      .data_o(st_dout[g])
    );
  end

  // Stage registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        sa_q[i]   <= '0;
        op_q[i]   <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        if (ld_en[i]) begin
          data_q[i] <= st_dout[i];
          tag_q[i]  <= st_tag[i];
          sa_q[i]   <= st_sa[i];
          op_q[i]   <= st_op[i];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s0        = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_execute_alu_shift_pipe.sv
// Randomised and directed bench for execute_alu_shift_pipe: one WIDTH=32/STAGES=2
// instance plus a sweep over other WIDTH/STAGES builds, all against a reference model.
module tb_execute_alu_shift_pipe;
  import execute_alu_shift_pipe_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   sweep_go = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Plain-arithmetic model on a 128-bit scratch so any shift by 0..w is well defined.
  function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] d,
                                            input int sa, input int w);
    logic [127:0] m, x, r;
    m = (128'd1 << w) - 128'd1;
    x = {64'd0, d} & m;
    case (op)
      ALU_SHIFT_SRL: r = x >> sa;
      ALU_SHIFT_SRA: r = (x >> sa) | (x[w-1] ? (m & ~(m >> sa)) : 128'd0);
      ALU_SHIFT_ROL: r = (x << sa) | (x >> (w - sa));
      ALU_SHIFT_ROR: r = (x >> sa) | (x << (w - sa));
      default:       r = x << sa;
    endcase
    r = r & m;
    return r[63:0];
  endfunction

  // Main instance
  logic        flush, in_valid, in_ready, sa_sel, out_valid, out_ready;
  logic [31:0] d0, s0;
  logic [4:0]  sa0, sa1;
  logic [2:0]  sel;
  logic [5:0]  in_tag, out_tag;
  bit          rnd_bp = 1'b0;
  logic        rnd_or = 1'b1;
  logic        or_fix;
  assign out_ready = rnd_bp ? rnd_or : or_fix;

  execute_alu_shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(6)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .sa0(sa0), .sa1(sa1), .sa_sel(sa_sel), .sel(sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .s0(s0), .out_tag(out_tag)
  );

  always @(posedge clk) if (rnd_bp) begin
    #1;
    rnd_or = ($urandom_range(0, 3) != 0);
  end

  exp_t        mq[$];
  exp_t        me;
  logic [31:0] pend_exp;
  bit          pend_lat;
  logic [31:0] hold_s0;
  logic [5:0]  hold_tag;
  bit          hold_v = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      mq.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        check_eq("hold_s0", s0, hold_s0);
        check_eq("hold_tag", out_tag, hold_tag);
      end
      hold_v   = out_valid && !out_ready;
      hold_s0  = s0;
      hold_tag = out_tag;
      if (out_valid && out_ready) begin
        if (mq.size() == 0) check_eq("spurious_out", out_valid, 0);
        else begin
          me = mq.pop_front();
          check_eq("result", s0, me.res);
          check_eq("tag", out_tag, me.tag);
          if (me.lat) check_eq("latency", cyc - me.acc, 2);
        end
      end
      if (flush) mq.delete();
      if (in_valid && in_ready && !flush) mq.push_back('{64'(pend_exp), in_tag, cyc, pend_lat});
    end
  end

  task automatic present(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a0,
                         input logic [4:0] a1, input logic ss, input logic [5:0] tg,
                         input logic [31:0] ex, input bit lat);
    in_valid = 1'b1; sel = op; d0 = d; sa0 = a0; sa1 = a1; sa_sel = ss; in_tag = tg;
    pend_exp = ex; pend_lat = lat;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !flush) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq({tag, "_accept_timeout"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a0,
                      input logic [4:0] a1, input logic ss, input logic [5:0] tg,
                      input logic [31:0] ex, input bit lat);
    present(op, d, a0, a1, ss, tg, ex, lat);
    wait_accept("send");
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((mq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, mq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Sweep instances: (32,1), (32,5), (64,5)
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W  = (g == 2) ? 64 : 32;
    localparam int S  = (g == 0) ? 1 : 5;
    localparam int SA = $clog2(W);

    logic          iv, ir, ov, ordy, ss;
    logic [W-1:0]  d, s;
    logic [SA-1:0] a0, a1;
    logic [2:0]    op;
    logic [5:0]    tg, otg;
    logic [63:0]   r64;
    exp_t          q[$];
    exp_t          e;
    bit            ph = 1'b0;
    bit            done = 1'b0;

    execute_alu_shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(6)) u_dut (
      .clk(clk), .resetn(resetn), .flush(1'b0), .in_valid(iv), .in_ready(ir),
      .d0(d), .sa0(a0), .sa1(a1), .sa_sel(ss), .sel(op), .in_tag(tg),
      .out_valid(ov), .out_ready(ordy), .s0(s), .out_tag(otg)
    );

    always @(negedge clk) if (resetn) begin
      if (ov && ordy) begin
        if (q.size() == 0) check_eq("sw_spurious_out", ov, 0);
        else begin
          e = q.pop_front();
          check_eq("sw_result", 64'(s), e.res);
          check_eq("sw_tag", otg, e.tag);
          if (e.lat && !ph) check_eq("sw_latency", cyc - e.acc, S);
        end
      end
      if (iv && ir) q.push_back('{ref_shift(op, 64'(d), ss ? int'(a1) : int'(a0), W), tg, cyc, !ph});
    end

    initial begin
      int n;
      iv = 1'b0; ordy = 1'b1; d = '0; a0 = '0; a1 = '0; ss = 1'b0; op = '0; tg = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int k = 0; k < 400; k++) begin
        ph   = (k >= 200);
        r64  = {$urandom, $urandom};
        iv   = ($urandom_range(0, 4) != 0);
        d    = r64[W-1:0];
        a0   = SA'($urandom);
        a1   = SA'($urandom);
        ss   = 1'($urandom_range(0, 1));
        op   = 3'($urandom_range(0, 7));
        tg   = 6'(k);
        ordy = ph ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(posedge clk); #1;
      end
      iv = 1'b0;
      ordy = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("sw_drain", q.size(), 0);
      done = 1'b1;
    end
  end

  logic [63:0] rexp;
  logic [31:0] rd;
  logic [4:0]  ra0, ra1;
  logic [2:0]  rop;
  logic        rss;

  initial begin
    int n;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; or_fix = 1'b1;
    sel = '0; d0 = '0; sa0 = '0; sa1 = '0; sa_sel = 1'b0; in_tag = '0;
    pend_exp = '0; pend_lat = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_s0", s0, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;

    // All five ops back to back
    send(ALU_SHIFT_SLL, 32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd1, 32'h0000_0F10, 1'b1);
    send(ALU_SHIFT_SRL, 32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd2, 32'h0800_000F, 1'b1);
    send(ALU_SHIFT_SRA, 32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd3, 32'hF800_000F, 1'b1);
    send(ALU_SHIFT_ROL, 32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd4, 32'h0000_0F18, 1'b1);
    send(ALU_SHIFT_ROR, 32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd5, 32'h1800_000F, 1'b1);
    send(3'd6,          32'h8000_00F1, 5'd4, 5'd0, 1'b0, 6'd6, 32'h0000_0F10, 1'b1);
    drain("ops");

    // Edge amounts through sa1
    send(ALU_SHIFT_SRA, 32'h8000_0000, 5'd0, 5'd31, 1'b1, 6'd7,  32'hFFFF_FFFF, 1'b1);
    send(ALU_SHIFT_SRL, 32'h8000_0000, 5'd0, 5'd31, 1'b1, 6'd8,  32'h0000_0001, 1'b1);
    send(ALU_SHIFT_ROL, 32'h8000_0000, 5'd0, 5'd31, 1'b1, 6'd9,  32'h4000_0000, 1'b1);
    send(ALU_SHIFT_ROR, 32'h8000_0000, 5'd0, 5'd31, 1'b1, 6'd10, 32'h0000_0001, 1'b1);
    send(ALU_SHIFT_SLL, 32'h8000_0001, 5'd0, 5'd31, 1'b1, 6'd11, 32'h8000_0000, 1'b1);
    for (int k = 0; k < 8; k++)
      send(3'(k), 32'hDEAD_BEEF, 5'd0, 5'd31, 1'b0, 6'(12 + k), 32'hDEAD_BEEF, 1'b1);
    drain("edge");

    // Backpressure: third op must wait while two sit in the pipe
    or_fix = 1'b0;
    send(ALU_SHIFT_SRL, 32'h1234_5678, 5'd8, 5'd0, 1'b0, 6'd21, 32'h0012_3456, 1'b0);
    send(ALU_SHIFT_ROR, 32'h1234_5678, 5'd8, 5'd0, 1'b0, 6'd22, 32'h7812_3456, 1'b0);
    present(ALU_SHIFT_ROL, 32'h1234_5678, 5'd8, 5'd0, 1'b0, 6'd23, 32'h3456_7812, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    or_fix = 1'b1;
    wait_accept("bp");
    drain("bp");

    // Flush kills two in flight plus the op presented alongside it
    or_fix = 1'b0;
    send(ALU_SHIFT_SLL, 32'h0000_0001, 5'd3, 5'd0, 1'b0, 6'd31, 32'h0000_0008, 1'b0);
    send(ALU_SHIFT_SRL, 32'h0000_0100, 5'd3, 5'd0, 1'b0, 6'd32, 32'h0000_0020, 1'b0);
    present(ALU_SHIFT_SRA, 32'hF000_0000, 5'd4, 5'd0, 1'b0, 6'd33, 32'hFF00_0000, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    or_fix = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("flush_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(ALU_SHIFT_ROR, 32'h0000_00FF, 5'd4, 5'd0, 1'b0, 6'd34, 32'hF000_000F, 1'b1);
    drain("flush");

    // Reset in the middle of two in-flight ops
    send(ALU_SHIFT_SLL, 32'h0000_0003, 5'd1, 5'd0, 1'b0, 6'd40, 32'h0000_0006, 1'b1);
    send(ALU_SHIFT_SLL, 32'h0000_0003, 5'd2, 5'd0, 1'b0, 6'd41, 32'h0000_000C, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_s0", s0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("midrst_idle", out_valid, 0);
    end
    @(posedge clk); #1;

    // Random stream with random consumer stalls
    rnd_bp = 1'b1;
    for (int k = 0; k < 150; k++) begin
      rop  = 3'($urandom_range(0, 7));
      rd   = $urandom;
      ra0  = 5'($urandom);
      ra1  = 5'($urandom);
      rss  = 1'($urandom_range(0, 1));
      rexp = ref_shift(rop, {32'd0, rd}, rss ? int'(ra1) : int'(ra0), 32);
      send(rop, rd, ra0, ra1, rss, 6'(k), rexp[31:0], 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_bp = 1'b0;
    drain("rnd");

    sweep_go = 1'b1;
    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check_eq("sweep_complete", {61'd0, g_sw[2].done, g_sw[1].done, g_sw[0].done}, 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
